lj24_frame_fifo: RTL and testbench

Stereo frame buffer between the synth sample engine and the left-justified 24-bit serial transmitter. Accepts one 24-bit left/right sample pair per handshake and stores each channel as a left-justified 32-bit word, left first. Presents the single-cycle `fifo_rdreq` / `fifo_empty` / `fifo_data` read port the transmitter consumes. Frames are written atomically so the transmitter's L/R word alternation never desynchronises.

---
 rtl/lj24_pkg.sv | 18 +
 rtl/lj24_fifo_ram.sv | 35 +++
 rtl/lj24_frame_fifo.sv | 130 +++++++++++++
 tb/tb_lj24_frame_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lj24_pkg.sv
// Shared widths, write-FSM state type and the left-justified packing helper
// for the lj24 stereo frame FIFO.
package lj24_pkg;

  localparam int SAMPLE_W = 24;
  localparam int WORD_W   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WR_R = 1'b1
  } wr_state_t;

  // Sample MSB lands on word bit 31; the low pad bits are zero.
  function automatic logic [WORD_W-1:0] pack_lj_word(input logic [SAMPLE_W-1:0] sample);
    return {sample, {(WORD_W - SAMPLE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/lj24_fifo_ram.sv
// Simple dual-port word store: synchronous write, read-enabled output register
// that doubles as the transmitter-facing data register.
module lj24_fifo_ram
  import lj24_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Holds its value between reads so an empty-FIFO request repeats the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lj24_frame_fifo.sv
// Stereo frame FIFO: one L/R pair per handshake, stored as two left-justified
// words (L first). Optional level/overflow status with LJ24_FIFO_STATUS_EN.
module lj24_frame_fifo
  import lj24_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [SAMPLE_W-1:0]   l_sample,
  input  logic [SAMPLE_W-1:0]   r_sample,
  input  logic                  fifo_rdreq,
  output logic                  fifo_empty,
  output logic [WORD_W-1:0]     fifo_data
`ifdef LJ24_FIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Largest count at which two free words remain for a whole frame.
  localparam logic [DEPTH_LOG2:0] READY_MAX = (DEPTH_LOG2 + 1)'(DEPTH - 2);

  wr_state_t             state_reg, state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [SAMPLE_W-1:0]   r_hold_reg;
  logic                  frame_ready_reg, frame_ready_next;
  logic                  fifo_empty_reg, fifo_empty_next;
  logic                  accept, wr_en, rd_en;
  logic [WORD_W-1:0]     wr_data;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = pack_lj_word(l_sample);
    case (state_reg)
      IDLE: begin
        if (frame_valid && frame_ready_reg) begin
          accept     = 1'b1;
          wr_en      = 1'b1;
          state_next = WR_R;
        end
      end
      WR_R: begin
        wr_en      = 1'b1;
        wr_data    = pack_lj_word(r_hold_reg);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Empty and ready are registered from next-state values so no input reaches an output.
  always_comb begin
    rd_en      = fifo_rdreq && !fifo_empty_reg;
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    fifo_empty_next  = (count_next == '0);
    frame_ready_next = (state_next == IDLE) && (count_next <= READY_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      r_hold_reg      <= '0;
      frame_ready_reg <= 1'b0;
      fifo_empty_reg  <= 1'b1;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      frame_ready_reg <= frame_ready_next;
      fifo_empty_reg  <= fifo_empty_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (accept) begin
        r_hold_reg <= r_sample;
      end
    end
  end

  lj24_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en),
    .waddr   (wr_ptr_reg),
    .wdata   (wr_data),
    .re      (rd_en),
    .raddr   (rd_ptr_reg),
    .rdata   (fifo_data)
  );

  assign frame_ready = frame_ready_reg;
  assign fifo_empty  = fifo_empty_reg;

`ifdef LJ24_FIFO_STATUS_EN
  logic overflow_reg;

  // Sticky: upstream offered a frame while IDLE could not take it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
    end else if (state_reg == IDLE && frame_valid && !frame_ready_reg) begin
      overflow_reg <= 1'b1;
    end
  end

  assign level    = count_reg;
  assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_lj24_frame_fifo.sv
// Self-checking bench for lj24_frame_fifo: table vectors, hand-written corner
// sequences and a randomized stream checked against a word-queue model.
module tb_lj24_frame_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_valid;
  logic        frame_ready;
  logic [23:0] l_sample;
  logic [23:0] r_sample;
  logic        fifo_rdreq;
  logic        fifo_empty;
  logic [31:0] fifo_data;
`ifdef LJ24_FIFO_STATUS_EN
  logic [4:0]  level;
  logic        overflow;
`endif

  always #5 clk = ~clk;

  lj24_frame_fifo #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .l_sample    (l_sample),
    .r_sample    (r_sample),
    .fifo_rdreq  (fifo_rdreq),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data)
`ifdef LJ24_FIFO_STATUS_EN
    ,
    .level       (level),
    .overflow    (overflow)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] lj_word(input logic [23:0] s);
    return {s, 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input bit track);
    int t = 0;
    frame_valid = 1'b1;
    l_sample    = l;
    r_sample    = r;
    while (frame_ready !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (frame_ready !== 1'b1) begin
      bound_fail("send_frame");
      frame_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      frame_valid = 1'b0;
      if (track) begin
        exp_q.push_back(lj_word(l));
        exp_q.push_back(lj_word(r));
      end
      $display("wr  L=%h R=%h", l, r);
    end
  endtask

  task automatic read_word(output logic [31:0] d);
    int t = 0;
    while (fifo_empty !== 1'b0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (fifo_empty !== 1'b0) bound_fail("read_wait");
    fifo_rdreq = 1'b1;
    @(posedge clk); #1;
    fifo_rdreq = 1'b0;
    d = fifo_data;
    $display("rd  data=%h", d);
  endtask

  task automatic read_check(input string name);
    logic [31:0] d;
    read_word(d);
    if (exp_q.size() == 0) bound_fail({name, "_model_empty"});
    else check(name, d, exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [23:0] la, ra, lb, rb, lc, rc;

    vecs[0] = '{24'h123456, 24'hABCDEF, 32'h12345600, 32'hABCDEF00};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 32'h80000000, 32'h7FFFFF00};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFF00};
    vecs[3] = '{24'h000001, 24'hFFFFFE, 32'h00000100, 32'hFFFFFE00};
    vecs[4] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
    vecs[5] = '{24'hC00000, 24'h3FFFFF, 32'hC0000000, 32'h3FFFFF00};

    reset_n     = 1'b0;
    frame_valid = 1'b0;
    fifo_rdreq  = 1'b0;
    l_sample    = '0;
    r_sample    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_data", fifo_data, 32'd0);
    check("rst_ready", 32'(frame_ready), 32'd0);
`ifdef LJ24_FIFO_STATUS_EN
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`endif
    reset_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(frame_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(frame_ready), 32'd1);

    // Read request on an empty FIFO is ignored.
    fifo_rdreq = 1'b1;
    @(posedge clk); #1;
    fifo_rdreq = 1'b0;
    check("empty_rd_data", fifo_data, 32'd0);
    check("empty_rd_empty", 32'(fifo_empty), 32'd1);

    // Table vectors: one frame in, two words out, FIFO empty again.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].l, vecs[i].r, 1'b0);
      read_word(d);
      check("tbl_l", d, vecs[i].exp_l);
      read_word(d);
      check("tbl_r", d, vecs[i].exp_r);
      check("tbl_empty", 32'(fifo_empty), 32'd1);
    end

    // Fill to full with 9 offered frames.
    for (int i = 0; i < 8; i++) begin
      send_frame(24'($urandom), 24'($urandom), 1'b1);
    end
    la = 24'($urandom);
    ra = 24'($urandom);
    frame_valid = 1'b1;
    l_sample    = la;
    r_sample    = ra;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("full_ready_low", 32'(frame_ready), 32'd0);
    end
`ifdef LJ24_FIFO_STATUS_EN
    check("full_level", 32'(level), 32'd16);
    check("full_overflow", 32'(overflow), 32'd1);
`endif
    read_check("full_rd1");
    check("ready_after_rd1", 32'(frame_ready), 32'd0);
`ifdef LJ24_FIFO_STATUS_EN
    check("level_after_rd1", 32'(level), 32'd15);
`endif
    read_check("full_rd2");
    check("ready_after_rd2", 32'(frame_ready), 32'd1);
    send_frame(la, ra, 1'b1);
    for (int i = 0; i < 16; i++) begin
      read_check("full_drain");
    end
    check("full_drain_empty", 32'(fifo_empty), 32'd1);

    // Simultaneous read and write with four words stored.
    la = 24'h111111; ra = 24'h222222;
    lb = 24'h333333; rb = 24'h444444;
    lc = 24'h555555; rc = 24'h666666;
    send_frame(la, ra, 1'b1);
    send_frame(lb, rb, 1'b1);
    @(posedge clk); #1;
    check("rw_ready", 32'(frame_ready), 32'd1);
    frame_valid = 1'b1;
    l_sample    = lc;
    r_sample    = rc;
    fifo_rdreq  = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    fifo_rdreq  = 1'b0;
    exp_q.push_back(lj_word(lc));
    exp_q.push_back(lj_word(rc));
    check("rw_data", fifo_data, exp_q.pop_front());
`ifdef LJ24_FIFO_STATUS_EN
    check("rw_level_same", 32'(level), 32'd4);
    @(posedge clk); #1;
    check("rw_level_r", 32'(level), 32'd5);
`endif
    for (int i = 0; i < 5; i++) begin
      read_check("rw_drain");
    end
    check("rw_empty", 32'(fifo_empty), 32'd1);

    // Reset while the R word is still pending.
    send_frame(24'hDEAD01, 24'hBEEF02, 1'b0);
    reset_n = 1'b0;
    #2;
    check("midrst_empty_async", 32'(fifo_empty), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_empty", 32'(fifo_empty), 32'd1);
    check("midrst_data", fifo_data, 32'd0);
    check("midrst_ready", 32'(frame_ready), 32'd1);
    send_frame(24'h0A0B0C, 24'h0D0E0F, 1'b1);
    read_check("midrst_l");
    read_check("midrst_r");
    check("midrst_final_empty", 32'(fifo_empty), 32'd1);

    // Randomized stream through a slow reader.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          send_frame(24'($urandom), 24'($urandom), 1'b1);
        end
      end
      begin
        int  got  = 0;
        int  cyc  = 0;
        bit  pend = 1'b0;
        while (got < 80 && cyc < 20000) begin
          @(posedge clk); #1;
          cyc++;
          if (pend) begin
            pend       = 1'b0;
            fifo_rdreq = 1'b0;
            got++;
            $display("rd  data=%h", fifo_data);
            if (exp_q.size() == 0) bound_fail("stream_model_empty");
            else check("stream", fifo_data, exp_q.pop_front());
          end else if (fifo_empty == 1'b0 && $urandom_range(0, 2) == 0) begin
            fifo_rdreq = 1'b1;
            pend       = 1'b1;
          end
        end
        if (got < 80) bound_fail("stream_reader");
      end
    join
    check("stream_empty", 32'(fifo_empty), 32'd1);
    check("stream_model_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
